// File: rtl/seg7_result_display.sv
// Result display stage: captures a 10-bit arithmetic result on load and scans it
// across a 4-digit common-anode seven-segment display, decoded by operation mode.
module seg7_result_display #(
  parameter int unsigned DIGIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [9:0] result,
  input  logic [1:0] mode,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned   CW       = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    MODE_RAW0  = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_FLOAT = 2'd2,
    MODE_RAW3  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    SYM_HEX,
    SYM_BLANK,
    SYM_DASH
  } sym_e;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [9:0]    r_cap_val;
  mode_e         r_cap_mode;
  logic          r_shown;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic          w_cnt_last;
  logic [9:0]    w_mag;
  logic [3:0]    w_nib;
  sym_e          w_sym;
  logic          w_dp_on;
  logic [6:0]    w_hex;
  logic [6:0]    w_seg;
  logic [3:0]    w_an;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Scan counter and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_cnt_last) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cap_val  <= '0;
      r_cap_mode <= MODE_RAW0;
      r_shown    <= 1'b0;
    end else if (load) begin
      r_cap_val  <= result;
      r_cap_mode <= mode_e'(mode);
      r_shown    <= 1'b1;
    end
  end

  // 10'h200 negates to itself, which reads correctly as unsigned magnitude 0x200.
  assign w_mag = r_cap_val[9] ? (~r_cap_val + 10'd1) : r_cap_val;

  always_comb begin
    w_nib   = '0;
    w_sym   = SYM_HEX;
    w_dp_on = 1'b0;
    if (!r_shown) begin
      w_sym = SYM_DASH;
    end else begin
      unique case (r_cap_mode)
        MODE_FIXED: begin
          unique case (r_idx)
            2'd3:    w_sym = r_cap_val[9] ? SYM_DASH : SYM_BLANK;
            2'd2:    w_nib = {2'b00, w_mag[9:8]};
            2'd1:    w_nib = w_mag[7:4];
            default: w_nib = w_mag[3:0];
          endcase
        end
        MODE_FLOAT: begin
          unique case (r_idx)
            2'd3:    w_sym = r_cap_val[9] ? SYM_DASH : SYM_BLANK;
            2'd2:    w_nib = {3'b000, r_cap_val[8]};
            2'd1: begin
              w_nib   = r_cap_val[7:4];
              w_dp_on = 1'b1;
            end
            default: w_nib = r_cap_val[3:0];
          endcase
        end
        default: begin
          unique case (r_idx)
            2'd3:    w_sym = SYM_BLANK;
            2'd2:    w_nib = {2'b00, r_cap_val[9:8]};
            2'd1:    w_nib = r_cap_val[7:4];
            default: w_nib = r_cap_val[3:0];
          endcase
        end
      endcase
    end
  end

  assign w_hex = hex_to_seg(w_nib);

  always_comb begin
    w_seg = w_hex;
    unique case (w_sym)
      SYM_BLANK: w_seg = SEG_BLANK;
      SYM_DASH:  w_seg = SEG_DASH;
      default:   w_seg = w_hex;
    endcase
  end

  assign w_an = ~(4'b0001 << r_idx);

  // Anodes, segments and dp share one register so a digit never sees a mixed frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= '1;
      r_seg <= '1;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= ~w_dp_on;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: doc/seg7_result_display.md
# seg7_result_display

Downstream output stage for the fixed/float arithmetic datapath. It captures the 10-bit result when the datapath signals completion and shows it on a 4-digit, common-anode seven-segment display. The display is scanned one digit at a time and decoded according to the operation mode (fixed 5.5 or float 1.5.4). All display outputs are registered and glitch-free.

## Interface
- DIGIT_CYCLES, 100000: clock cycles each digit stays active; legal range is 2 or more.
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  capture strobe, high for one or more cycles when the result is valid
- result  in  10  datapath result
- mode  in  2  operation select: 1 = fixed 5.5 two's complement, 2 = float {sign, mantissa[8:4], exponent[3:0]}, 0/3 = raw
- an  out  4  digit anodes, active-low; an[0] is the rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation
- **Capture**
  - On every clk edge with load=1: cap_val<=result, cap_mode<=mode, shown<=1.
  - load held high recaptures every cycle.
- **Scan**
  - cnt counts 0..DIGIT_CYCLES-1.
  - On terminal count: cnt<=0 and idx<=idx+1, wrapping 3->0.
- **Digit content** (d3 is leftmost)
  - shown=0: all digits show dash (7'b0111111); dp is off.
  - mode 1 (fixed):
    - mag = cap_val[9] ? (~cap_val+1) : cap_val, computed as an unsigned 10-bit value (10'h200 gives 0x200).
    - d3 = dash if cap_val[9], else blank.
    - d2 = {2'b00, mag[9:8]}, d1 = mag[7:4], d0 = mag[3:0].
    - dp is off.
  - mode 2 (float):
    - d3 = dash if cap_val[9], else blank.
    - d2 = {3'b000, cap_val[8]}, d1 = cap_val[7:4], d0 = cap_val[3:0].
    - dp is on only while d1 is active; it separates mantissa from exponent.
  - mode 0/3 (raw):
    - d3 = blank, d2 = {2'b00, cap_val[9:8]}, d1 = cap_val[7:4], d0 = cap_val[3:0].
    - dp is off.
- **Hex encoding** (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- **Output register**
  - an, seg and dp are registered together from the current idx, cap_* and shown.
  - an = one-hot-low of idx.
  - No two anodes are ever low simultaneously.

## Timing
- **Reset values**
  - an=4'b1111, seg=7'b1111111, dp=1.
  - cnt=0, idx=0, shown=0, cap_val=0, cap_mode=0.
- **Start-up**
  - First edge after reset release: an=4'b1110, seg=dash.
- **Load latency**
  - load sampled high at edge N: cap_* update at N.
  - The outputs show the new value from edge N+1 for whichever digit is active.
- **Digit switch**
  - idx changes at the edge where cnt=DIGIT_CYCLES-1.
  - an/seg change one edge later.
  - Each digit is active for exactly DIGIT_CYCLES cycles.
- **Load coincident with digit switch**
  - The next output register uses the new idx and the new cap_* together.
  - No mixed frame occurs.
- **Reset mid-scan**
  - Returns immediately, asynchronously, to the reset values.
  - The captured value is discarded, so the display shows dashes until the next load.
- mode changing without load has no effect; only cap_mode is used.

## Test plan
- **Reset and pre-load:** DIGIT_CYCLES=4, no load.
  - Outputs are the reset values while reset is high.
  - After release, an cycles 1110, 1101, 1011, 0111, 1110, each for 4 cycles.
  - seg=0111111 throughout, dp=1.
- **Fixed positive:** load with result=10'h0A3, mode=1.
  - Over one scan d3 is blank, d2=0 (1000000), d1=A (0001000), d0=3 (0110000).
  - dp=1 always.
- **Fixed negative boundaries:**
  - result=10'h3F0 shows "-010".
  - result=10'h200 shows "-200".
  - result=10'h1FF shows " 1FF".
- **Float:** result=10'b1_10110_0101, mode=2 shows "-165".
  - dp=0 only while an=1101; a positive sign gives d3 blank.
- **Latency/coincidence:** pulse load one cycle with result=10'h011, mode=0, at the edge where cnt=3 (DIGIT_CYCLES=4).
  - The next edge shows an=1101 with seg=1 (1111001).
  - The prior value is never shown on the new digit.
- **Reset mid-scan:** with "-165" displayed, assert reset asynchronously between edges.
  - Outputs go to the reset values immediately.
  - After release, dashes are shown until the next load.
